adc_spi_responder: RTL and testbench

Behavioural SPI-slave model of the 8-channel 12-bit serial ADC (LTC2308-style) driven by the Nios ADC controller over `ADC_SCLK`/`ADC_CONVST`/`ADC_SDI`/`ADC_SDO`. It sits on the ADC side of the bus in simulation benches and FPGA-loopback builds. It captures the 6-bit configuration word the master shifts in and returns the previous frame's conversion result MSB-first. All bus pins are oversampled on `CLOCK_50`; the block holds no clock derived from `ADC_SCLK`.

---
 rtl/adc_resp_pkg.sv | 21 ++
 rtl/adc_spi_responder_sync_edge.sv | 30 +++
 rtl/adc_spi_responder.sv | 174 +++++++++++++++++
 tb/tb_adc_spi_responder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/adc_resp_pkg.sv
// Shared types and constants for the LTC2308-style ADC SPI responder.
// Config word layout: S/D, O/S, S1, S0, UNI, SLP (MSB to LSB).
package adc_resp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    CONV  = 2'd2
  } state_t;

  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  localparam logic [5:0]  CFG_RST = 6'b100010;
  localparam logic [11:0] BIP_OFS = 12'h800;

endpackage

// File: rtl/adc_spi_responder_sync_edge.sv
// Two-flop synchronizer with a registered edge detector.
// Rise/fall pulses are one CLOCK_50 cycle wide.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_s1   <= i_d;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_prev;
  assign o_fall = ~r_s2 & r_prev;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI-slave model of an 8-channel 12-bit ADC, oversampled on CLOCK_50.
// Define ADC_RESP_TCONV_EN to add a timed CONV state and tconv_err.
module adc_spi_responder
  import adc_resp_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int N_CH   = 8,
  parameter int CFG_W  = 6
`ifdef ADC_RESP_TCONV_EN
  ,
  parameter int T_CONV_CYCLES = 80
`endif
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET_N,
  input  logic                     ADC_SCLK,
  input  logic                     ADC_CONVST,
  input  logic                     ADC_SDI,
  output logic                     ADC_SDO,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  output logic [CFG_W-1:0]         cfg_word,
`ifdef ADC_RESP_TCONV_EN
  output logic                     tconv_err,
`endif
  output logic                     frame_done,
  output logic                     frame_err
);

  logic w_sclk_rise, w_sclk_fall;
  logic w_cs_rise, w_cs_fall;
  logic w_sdi_rise, w_sdi_fall;

  sync_edge u_sclk (
    .clk(CLOCK_50), .rst_n(RESET_N), .i_d(ADC_SCLK),
    .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );
  sync_edge u_cs (
    .clk(CLOCK_50), .rst_n(RESET_N), .i_d(ADC_CONVST),
    .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );
  sync_edge u_sdi (
    .clk(CLOCK_50), .rst_n(RESET_N), .i_d(ADC_SDI),
    .o_rise(w_sdi_rise), .o_fall(w_sdi_fall)
  );

  state_t              r_state, w_state;
  logic [DATA_W-1:0]   r_shift_out, w_shift_out;
  logic [CFG_W-1:0]    r_shift_in, w_shift_in;
  logic [3:0]          r_bit_cnt, w_bit_cnt;
  logic [CFG_W-1:0]    r_cfg, w_cfg;
  logic [DATA_W-1:0]   r_result, w_result;
  logic                r_done, w_done;
  logic                r_err, w_err;
  logic                r_sdi, w_sdi;
`ifdef ADC_RESP_TCONV_EN
  localparam int TW = $clog2(T_CONV_CYCLES + 1);
  logic [TW-1:0]       r_tcnt, w_tcnt;
  logic                r_tconv_err, w_tconv_err;
`endif

  function automatic logic [DATA_W-1:0] f_conv(input logic [CFG_W-1:0] c);
    logic [2:0] ch;
    ch = {c[CFG_OS], c[CFG_S1], c[CFG_S0]};
    if (c[CFG_SLP]) return '0;
    return ch_data[ch*DATA_W +: DATA_W] ^
           (c[CFG_UNI] ? '0 : DATA_W'(BIP_OFS));
  endfunction

  always_comb begin
    w_state     = r_state;
    w_shift_out = r_shift_out;
    w_shift_in  = r_shift_in;
    w_bit_cnt   = r_bit_cnt;
    w_cfg       = r_cfg;
    w_result    = r_result;
    w_done      = 1'b0;
    w_err       = 1'b0;
    // SDI level rebuilt from its edge pulses, one cycle behind the sync
    w_sdi       = w_sdi_rise ? 1'b1 : (w_sdi_fall ? 1'b0 : r_sdi);
`ifdef ADC_RESP_TCONV_EN
    w_tcnt      = r_tcnt;
    w_tconv_err = r_tconv_err;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_state     = FRAME;
          w_shift_out = r_result;
          w_bit_cnt   = '0;
          w_shift_in  = '0;
        end
      end
      FRAME: begin
        if (w_cs_rise) begin
          w_done = 1'b1;
          w_err  = (r_bit_cnt != 4'(DATA_W));
          if (r_bit_cnt >= 4'(CFG_W)) w_cfg = r_shift_in;
`ifdef ADC_RESP_TCONV_EN
          w_state = CONV;
          w_tcnt  = TW'(T_CONV_CYCLES - 1);
`else
          w_state  = IDLE;
          w_result = f_conv(w_cfg);
`endif
        end else if (w_sclk_rise) begin
          if (r_bit_cnt < 4'(CFG_W))
            w_shift_in = {r_shift_in[CFG_W-2:0], r_sdi};
          if (r_bit_cnt != 4'hF) w_bit_cnt = r_bit_cnt + 4'd1;
        end else if (w_sclk_fall) begin
          w_shift_out = {r_shift_out[DATA_W-2:0], 1'b0};
        end
      end
`ifdef ADC_RESP_TCONV_EN
      CONV: begin
        if (w_cs_fall) begin
          // early frame: conversion abandoned, old result goes out
          w_tconv_err = 1'b1;
          w_state     = FRAME;
          w_shift_out = r_result;
          w_bit_cnt   = '0;
          w_shift_in  = '0;
        end else if (r_tcnt == '0) begin
          w_state  = IDLE;
          w_result = f_conv(r_cfg);
        end else begin
          w_tcnt = r_tcnt - 1'b1;
        end
      end
`endif
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= IDLE;
      r_shift_out <= '0;
      r_shift_in  <= '0;
      r_bit_cnt   <= '0;
      r_cfg       <= CFG_W'(CFG_RST);
      r_result    <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_sdi       <= 1'b0;
`ifdef ADC_RESP_TCONV_EN
      r_tcnt      <= '0;
      r_tconv_err <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      r_shift_out <= w_shift_out;
      r_shift_in  <= w_shift_in;
      r_bit_cnt   <= w_bit_cnt;
      r_cfg       <= w_cfg;
      r_result    <= w_result;
      r_done      <= w_done;
      r_err       <= w_err;
      r_sdi       <= w_sdi;
`ifdef ADC_RESP_TCONV_EN
      r_tcnt      <= w_tcnt;
      r_tconv_err <= w_tconv_err;
`endif
    end
  end

  assign ADC_SDO    = (r_state == FRAME) & r_shift_out[DATA_W-1];
  assign cfg_word   = r_cfg;
  assign frame_done = r_done;
  assign frame_err  = r_err;
`ifdef ADC_RESP_TCONV_EN
  assign tconv_err  = r_tconv_err;
`endif

endmodule

// File: tb/tb_adc_spi_responder.sv
// Scoreboard bench for adc_spi_responder: SPI master frames,
// expected SDO words queued at drive time and popped at frame end.
module tb_adc_spi_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sclk, convst, sdi;
  logic        sdo;
  logic [95:0] ch_data;
  logic [5:0]  cfg_word;
  logic        frame_done, frame_err;
`ifdef ADC_RESP_TCONV_EN
  logic        tconv_err;
`endif

  adc_spi_responder dut (
    .CLOCK_50(clk),
    .RESET_N(rst_n),
    .ADC_SCLK(sclk),
    .ADC_CONVST(convst),
    .ADC_SDI(sdi),
    .ADC_SDO(sdo),
    .ch_data(ch_data),
    .cfg_word(cfg_word),
`ifdef ADC_RESP_TCONV_EN
    .tconv_err(tconv_err),
`endif
    .frame_done(frame_done),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;

  always @(posedge clk) begin
    if (frame_done) done_cnt <= done_cnt + 1;
    if (frame_err)  ferr_cnt <= ferr_cnt + 1;
  end

  logic [11:0] chv [8];
  logic [5:0]  m_cfg;
  logic [11:0] m_result;
  logic [11:0] m_pend;
  logic [15:0] sb [$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] m_conv(input logic [5:0] c);
    logic [2:0]  ch;
    logic [11:0] v;
    ch = {c[4], c[3], c[2]};
    if (c[0]) return 12'h000;
    v = chv[ch];
    if (!c[1]) v = v ^ 12'h800;
    return v;
  endfunction

  task automatic spi_frame(input logic [5:0] cfg, input int n,
                           input bit short_gap);
    logic [15:0] rx;
    logic [15:0] exp;
    int d0, e0;
`ifdef ADC_RESP_TCONV_EN
    if (short_gap) repeat (12) @(negedge clk);
    else begin
      repeat (100) @(negedge clk);
      m_result = m_pend;
    end
`endif
    exp = '0;
    for (int i = 0; i < n; i++) begin
      if (i < 12) exp = {exp[14:0], m_result[11-i]};
      else        exp = {exp[14:0], 1'b0};
    end
    sb.push_back(exp);
    d0 = done_cnt;
    e0 = ferr_cnt;
    @(negedge clk) convst = 1'b0;
    repeat (6) @(negedge clk);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      sdi = (i < 6) ? cfg[5-i] : 1'b0;
      repeat (5) @(negedge clk);
      rx = {rx[14:0], sdo};
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (5) @(negedge clk);
    convst = 1'b1;
    repeat (8) @(negedge clk);
    check("sdo_word", 32'(rx), 32'(sb.pop_front()));
    check("frame_done", done_cnt - d0, 1);
    check("frame_err", ferr_cnt - e0, (n != 12) ? 1 : 0);
    if (n >= 6) m_cfg = cfg;
    m_pend = m_conv(m_cfg);
`ifndef ADC_RESP_TCONV_EN
    m_result = m_pend;
`endif
    check("cfg_word", 32'(cfg_word), 32'(m_cfg));
  endtask

  initial begin
    int d0;
    chv = '{12'hABC, 12'h111, 12'h222, 12'h001,
            12'h444, 12'h5A5, 12'h666, 12'h7E7};
    for (int k = 0; k < 8; k++) ch_data[k*12 +: 12] = chv[k];
    m_cfg    = 6'b100010;
    m_result = 12'h000;
    m_pend   = 12'h000;
    rst_n  = 1'b0;
    sclk   = 1'b0;
    convst = 1'b1;
    sdi    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sdo", 32'(sdo), 0);
    check("rst_cfg", 32'(cfg_word), 32'h22);
    check("rst_done", 32'(frame_done), 0);
    check("rst_err", 32'(frame_err), 0);
`ifdef ADC_RESP_TCONV_EN
    check("rst_tconv", 32'(tconv_err), 0);
`endif
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    spi_frame(6'b100010, 12, 1'b0);
    spi_frame(6'b110110, 12, 1'b0);
    spi_frame(6'b101100, 12, 1'b0);
    spi_frame(6'b000000, 4, 1'b0);
    spi_frame(6'b110001, 14, 1'b0);
    spi_frame(6'b100010, 12, 1'b0);

    d0 = done_cnt;
    @(negedge clk) convst = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      sdi = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_sdo", 32'(sdo), 0);
    check("midrst_cfg", 32'(cfg_word), 32'h22);
    convst = 1'b1;
    sdi    = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_nodone", done_cnt - d0, 0);
    m_cfg    = 6'b100010;
    m_result = 12'h000;
    m_pend   = 12'h000;

    spi_frame(6'b100010, 12, 1'b0);
    spi_frame(6'b101100, 12, 1'b0);

`ifdef ADC_RESP_TCONV_EN
    spi_frame(6'b100010, 12, 1'b1);
    check("tconv_set", 32'(tconv_err), 1);
    spi_frame(6'b100010, 12, 1'b0);
    check("tconv_hold", 32'(tconv_err), 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
